// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and shared memory port seen by mem_port_arbiter.
// The arbiter takes the slave view; the core/memory environment takes the master view.
interface mem_port_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  // Fetch-stage port
  logic                  i_req;
  logic [DATA_WIDTH-1:0] i_addr;
  logic [DATA_WIDTH-1:0] i_rdata;
  logic                  i_valid;
  logic                  i_err;
  // Memory-stage port
  logic                  d_req;
  logic                  d_we;
  logic [DATA_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [2:0]            d_mode;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_valid;
  logic                  d_err;
  // Shared memory port
  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [2:0]            mem_mode;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;
  // Pipeline stalls
  logic                  stall_F;
  logic                  stall_M;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_mode, mem_ack, mem_rdata,
    output i_rdata, i_valid, i_err, d_rdata, d_valid, d_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_mode, stall_F, stall_M
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_mode, mem_ack, mem_rdata,
    input  i_rdata, i_valid, i_err, d_rdata, d_valid, d_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_mode, stall_F, stall_M
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between the fetch stage and the memory stage.
// Data accesses win by default; a pending fetch is forced through after STARVE_MAX
// consecutive data grants. Every access ends in a one-cycle RESP state, and an access
// that never sees mem_ack is aborted after TIMEOUT busy cycles with an error pulse.
module mem_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StResp} state_e;

  state_e                state_q;
  logic [SW-1:0]         starve_q;
  logic [WW-1:0]         wait_q;
  logic                  mem_req_q, mem_we_q;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_wdata_q;
  logic [2:0]            mem_mode_q;
  logic [DATA_WIDTH-1:0] i_rdata_q, d_rdata_q;
  logic                  i_valid_q, i_err_q, d_valid_q, d_err_q;

  logic starve_full;
  assign starve_full = (starve_q == SW'(STARVE_MAX));

  // Arbitration FSM; all port-facing outputs are registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      starve_q    <= '0;
      wait_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_mode_q  <= 3'b000;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_valid_q   <= 1'b0;
      i_err_q     <= 1'b0;
      d_valid_q   <= 1'b0;
      d_err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          wait_q <= '0;
          if (bus.d_req && !(bus.i_req && starve_full)) begin
            state_q     <= StBusyD;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.d_we;
            mem_addr_q  <= bus.d_addr;
            mem_wdata_q <= bus.d_wdata;
            mem_mode_q  <= bus.d_mode;
            // Count only data grants that made a fetch wait; saturate at the limit.
            if (!bus.i_req)       starve_q <= '0;
            else if (!starve_full) starve_q <= starve_q + SW'(1);
          end else if (bus.i_req) begin
            state_q     <= StBusyI;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.i_addr;
            mem_wdata_q <= '0;
            mem_mode_q  <= 3'b001;
            starve_q    <= '0;
          end else begin
            starve_q <= '0;
          end
        end
        StBusyI, StBusyD: begin
          // An ack on the timeout cycle still wins and completes normally.
          if (bus.mem_ack) begin
            state_q   <= StResp;
            mem_req_q <= 1'b0;
            if (state_q == StBusyI) begin
              i_rdata_q <= bus.mem_rdata;
              i_valid_q <= 1'b1;
              i_err_q   <= 1'b0;
            end else begin
              d_rdata_q <= mem_we_q ? '0 : bus.mem_rdata;
              d_valid_q <= 1'b1;
              d_err_q   <= 1'b0;
            end
          end else begin
            wait_q <= wait_q + WW'(1);
            if (wait_q == WW'(TIMEOUT - 1)) begin
              state_q   <= StResp;
              mem_req_q <= 1'b0;
              if (state_q == StBusyI) begin
                i_rdata_q <= '0;
                i_valid_q <= 1'b1;
                i_err_q   <= 1'b1;
              end else begin
                d_rdata_q <= '0;
                d_valid_q <= 1'b1;
                d_err_q   <= 1'b1;
              end
            end
          end
        end
        StResp: begin
          // One dead cycle so requesters can drop or change their request.
          state_q   <= StIdle;
          i_valid_q <= 1'b0;
          i_err_q   <= 1'b0;
          d_valid_q <= 1'b0;
          d_err_q   <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_mode  = mem_mode_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.i_valid   = i_valid_q;
  assign bus.i_err     = i_err_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.d_err     = d_err_q;
  assign bus.stall_F   = bus.i_req & ~i_valid_q;
  assign bus.stall_M   = bus.d_req & ~d_valid_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of data words and addresses.
REQ-002 Parameter STARVE_MAX, default 4: consecutive data-side grants allowed while a fetch is pending.
REQ-003 Parameter TIMEOUT, default 255: cycles of mem_req without mem_ack before the access is aborted.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-006 i_req  input  1  fetch-stage read request; held with i_addr stable until i_valid.
REQ-007 i_addr  input  DATA_WIDTH  fetch address.
REQ-008 i_rdata  output  DATA_WIDTH  fetched instruction, valid while i_valid=1.
REQ-009 i_valid  output  1  one-cycle fetch completion pulse.
REQ-010 d_req, d_we  input  1 each  memory-stage request and write enable; held stable until d_valid.
REQ-011 d_addr, d_wdata  input  DATA_WIDTH each  memory-stage address and store data.
REQ-012 d_mode  input  3  access size: 001 word, 010 half, 011 byte, 100 unsigned half, 101 unsigned byte.
REQ-013 d_rdata  output  DATA_WIDTH  load data, valid while d_valid=1.
REQ-014 d_valid, d_err  output  1 each  one-cycle completion pulse; d_err=1 marks a timed-out access.
REQ-015 i_err  output  1  set with i_valid when the fetch timed out.
REQ-016 mem_req, mem_we  output  1 each  shared memory port request and write enable.
REQ-017 mem_addr, mem_wdata  output  DATA_WIDTH each  latched address and store data.
REQ-018 mem_mode  output  3  latched access size; 001 for every fetch.
REQ-019 mem_ack  input  1  one-cycle memory completion; mem_rdata is valid in the same cycle.
REQ-020 mem_rdata  input  DATA_WIDTH  memory read data.
REQ-021 stall_F, stall_M  output  1 each  combinational: i_req&~i_valid and d_req&~d_valid.

Function
REQ-022 The FSM SHALL have states IDLE, BUSY_I, BUSY_D, and RESP.
REQ-023 In IDLE with d_req=1, the arbiter SHALL grant data (latch d_addr/d_wdata/d_we/d_mode, go to BUSY_D), unless i_req=1 and starve_cnt=STARVE_MAX, in which case it grants fetch.
REQ-024 In IDLE with only i_req=1, the arbiter SHALL latch i_addr, force mem_we=0 and mem_mode=001, and go to BUSY_I.
REQ-025 starve_cnt SHALL increment on each data grant made while i_req=1, and clear on any fetch grant or when i_req=0 in IDLE.
REQ-026 starve_cnt SHALL saturate at STARVE_MAX.
REQ-027 mem_req SHALL be 1 exactly in BUSY_I and BUSY_D, with all mem_* fields driven from registers that stay constant for the whole access.
REQ-028 On mem_ack in BUSY_x, the arbiter SHALL register mem_rdata into x_rdata and go to RESP; x_valid SHALL be 1 for that single RESP cycle.
REQ-029 Load latency SHALL be grant edge + memory wait + 1 cycle (mem_ack to valid).
REQ-030 For a write, d_rdata SHALL be 0 when d_valid=1.
REQ-031 RESP SHALL ignore all requests and always return to IDLE, giving one idle cycle between accesses so that a requester can drop or change its request.
REQ-032 A wait counter SHALL clear on each grant and increment each BUSY cycle without mem_ack.
REQ-033 When the wait counter reaches TIMEOUT, the arbiter SHALL go to RESP with x_valid=1, x_err=1, and x_rdata=0; mem_req SHALL drop on that edge.
REQ-034 mem_ack outside BUSY_I/BUSY_D SHALL be ignored.
REQ-035 mem_ack on the same cycle the wait counter reaches TIMEOUT SHALL complete normally (err=0).
REQ-036 Requests arriving during BUSY or RESP SHALL wait; none is lost while its requester holds req.

Reset
REQ-037 When rst_n=0 at a clock edge, the arbiter SHALL set state=IDLE, starve_cnt=0, the wait counter to 0, and every registered output (mem_*, *_valid, *_err, *_rdata) to 0.
REQ-038 A reset during BUSY SHALL abort the access: mem_req=0 from the next cycle, and no valid pulse SHALL be issued for the aborted access.

Verification
REQ-039 Fetch-only, i_addr=0x100, memory acks 2 cycles after mem_req with 0x00500093 -> mem_mode=001, mem_we=0, i_rdata=0x00500093, i_valid for exactly one cycle, stall_F=1 until then.
REQ-040 Simultaneous i_req and d_req (sw, d_addr=0x2000, d_wdata=0xDEADBEEF, d_mode=001) -> data served first with mem_we=1; fetch is granted in the next IDLE after RESP.
REQ-041 i_req held and d_req re-issued every IDLE with STARVE_MAX=4 -> exactly 4 data grants, then one fetch grant, then starve_cnt=0.
REQ-042 Data load with memory never acking, TIMEOUT=255 -> mem_req falls after 255 BUSY cycles; d_valid=1, d_err=1, d_rdata=0.
REQ-043 rst_n=0 asserted in the 2nd BUSY_D cycle -> mem_req=0 next cycle, no d_valid; a subsequent request is served normally from IDLE.
REQ-044 Byte load d_mode=011 followed by unsigned half load d_mode=100 -> mem_mode matches each request and is stable throughout its BUSY period.
